// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin write-back port arbiter with register busy scoreboard
module wb_port_arbiter #(
    parameter int XLEN = 64,
    parameter int NREQ = 3,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*AW-1:0]   req_addr_i,
    input  logic [NREQ*XLEN-1:0] req_data_i,
    output logic                 wr_en_o,
    output logic [AW-1:0]        wr_addr_o,
    output logic [XLEN-1:0]      wr_data_o,
    input  logic                 issue_valid_i,
    input  logic [AW-1:0]        issue_rd_i,
    input  logic                 issue_rd_we_i,
    input  logic [AW-1:0]        issue_rs1_i,
    input  logic [AW-1:0]        issue_rs2_i,
    output logic                 stall_o
);

    localparam int PW   = $clog2(NREQ);
    localparam int NREG = 1 << AW;

    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win;
    logic [PW-1:0]   ptr_nxt;
    logic            found;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;
    logic            issue_accept;

    // Round-robin search starting at the pointer, wrapping at NREQ rather than a power of two.
    always_comb begin
        found       = 1'b0;
        win         = '0;
        req_ready_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = int'(ptr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_valid_i[j]) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
        if (found) req_ready_o[win] = 1'b1;
    end

    // Winner's payload and the pointer value that follows a handshake.
    always_comb begin
        sel_addr = req_addr_i[int'(win)*AW +: AW];
        sel_data = req_data_i[int'(win)*XLEN +: XLEN];
        ptr_nxt  = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
    end

    // Pointer advances only on a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= ptr_nxt;
        end
    end

    // Write stage: one cycle after the grant; writes to x0 are consumed but never enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else if (found) begin
            wr_en_o   <= (sel_addr != '0);
            wr_addr_o <= sel_addr;
            wr_data_o <= sel_data;
        end else begin
            wr_en_o   <= 1'b0;
        end
    end

    // Hazard detection against registers with an outstanding producer; no bypass from the write stage.
    always_comb begin
        stall_o = issue_valid_i &
                  (busy_q[issue_rs1_i] | busy_q[issue_rs2_i] | (issue_rd_we_i & busy_q[issue_rd_i]));
        issue_accept = issue_valid_i & ~stall_o & issue_rd_we_i & (issue_rd_i != '0);
    end

    // Scoreboard update: commit clears, then a new producer sets so it owns the register on a collision.
    always_comb begin
        busy_nxt = busy_q;
        if (wr_en_o) busy_nxt[wr_addr_o] = 1'b0;
        if (issue_accept) busy_nxt[issue_rd_i] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    localparam int XLEN = 64;
    localparam int NREQ = 3;
    localparam int AW   = 5;

    localparam logic [XLEN-1:0] DA = 64'hAAAA_0000_0000_000A;
    localparam logic [XLEN-1:0] DB = 64'hBBBB_0000_0000_000B;
    localparam logic [XLEN-1:0] DC = 64'hCCCC_0000_0000_000C;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ*AW-1:0]   req_addr_i;
    logic [NREQ*XLEN-1:0] req_data_i;
    logic                 wr_en_o;
    logic [AW-1:0]        wr_addr_o;
    logic [XLEN-1:0]      wr_data_o;
    logic                 issue_valid_i;
    logic [AW-1:0]        issue_rd_i;
    logic                 issue_rd_we_i;
    logic [AW-1:0]        issue_rs1_i;
    logic [AW-1:0]        issue_rs2_i;
    logic                 stall_o;

    int vectors     = 0;
    int miscompares = 0;

    wb_port_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_data_i    (req_data_i),
        .wr_en_o       (wr_en_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .issue_rd_we_i (issue_rd_we_i),
        .issue_rs1_i   (issue_rs1_i),
        .issue_rs2_i   (issue_rs2_i),
        .stall_o       (stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [AW-1:0] rd, input logic we,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        issue_valid_i = v;
        issue_rd_i    = rd;
        issue_rd_we_i = we;
        issue_rs1_i   = rs1;
        issue_rs2_i   = rs2;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_data_i  = '0;
        issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

        // reset state
        tick();
        tick();
        chk("rst_wr_en", 64'(wr_en_o), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr_o), 64'd0);
        chk("rst_wr_data", wr_data_o, 64'd0);
        chk("rst_ready_none", 64'(req_ready_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);

        // all three sources valid, addrs 5/6/7
        req_valid_i = 3'b111;
        req_addr_i  = {5'd7, 5'd6, 5'd5};
        req_data_i  = {DC, DB, DA};
        #1;
        chk("rst_ready_src0", 64'(req_ready_o), 64'b001);
        rst = 1'b0;

        tick();
        chk("rr0_wr_en", 64'(wr_en_o), 64'd1);
        chk("rr0_wr_addr", 64'(wr_addr_o), 64'd5);
        chk("rr0_wr_data", wr_data_o, DA);
        chk("rr0_ready", 64'(req_ready_o), 64'b010);
        tick();
        chk("rr1_wr_en", 64'(wr_en_o), 64'd1);
        chk("rr1_wr_addr", 64'(wr_addr_o), 64'd6);
        chk("rr1_wr_data", wr_data_o, DB);
        chk("rr1_ready", 64'(req_ready_o), 64'b100);
        tick();
        chk("rr2_wr_en", 64'(wr_en_o), 64'd1);
        chk("rr2_wr_addr", 64'(wr_addr_o), 64'd7);
        chk("rr2_wr_data", wr_data_o, DC);
        chk("rr2_ready", 64'(req_ready_o), 64'b001);
        tick();
        chk("rr3_wr_en", 64'(wr_en_o), 64'd1);
        chk("rr3_wr_addr", 64'(wr_addr_o), 64'd5);
        chk("rr3_ready", 64'(req_ready_o), 64'b010);

        // reset asserted mid-cycle with a write in flight
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_wr_en", 64'(wr_en_o), 64'd0);
        chk("midrst_wr_addr", 64'(wr_addr_o), 64'd0);
        chk("midrst_ready", 64'(req_ready_o), 64'b001);
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_wr_addr", 64'(wr_addr_o), 64'd5);
        chk("post_rst_ready", 64'(req_ready_o), 64'b010);

        // only sources 2 and 0, pointer at 1
        req_valid_i = 3'b101;
        #1;
        chk("wrap_ready_a", 64'(req_ready_o), 64'b100);
        tick();
        chk("wrap_addr_a", 64'(wr_addr_o), 64'd7);
        chk("wrap_ready_b", 64'(req_ready_o), 64'b001);
        tick();
        chk("wrap_addr_b", 64'(wr_addr_o), 64'd5);
        chk("wrap_ready_c", 64'(req_ready_o), 64'b100);
        tick();
        chk("wrap_addr_c", 64'(wr_addr_o), 64'd7);
        chk("wrap_ready_d", 64'(req_ready_o), 64'b001);

        // idle: enable drops, address holds
        req_valid_i = 3'b000;
        #1;
        chk("idle_ready", 64'(req_ready_o), 64'd0);
        tick();
        chk("idle_wr_en", 64'(wr_en_o), 64'd0);
        chk("idle_wr_addr_hold", 64'(wr_addr_o), 64'd7);

        // x0 write from source 1 (pointer still 0)
        req_valid_i = 3'b010;
        req_addr_i  = {5'd7, 5'd0, 5'd8};
        req_data_i  = {DC, 64'hDEAD, 64'h1234};
        #1;
        chk("x0_ready", 64'(req_ready_o), 64'b010);
        tick();
        req_valid_i = 3'b000;
        chk("x0_wr_en", 64'(wr_en_o), 64'd0);
        issue(1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        #1;
        chk("x0_no_busy", 64'(stall_o), 64'd0);

        // RAW: producer of x8 issues, consumer stalls until commit lands
        issue(1'b1, 5'd8, 1'b1, 5'd0, 5'd0);
        #1;
        chk("raw_issue_accept", 64'(stall_o), 64'd0);
        tick();
        issue(1'b1, 5'd0, 1'b0, 5'd8, 5'd0);
        req_valid_i = 3'b001;
        #1;
        chk("raw_stall_T", 64'(stall_o), 64'd1);
        chk("raw_alu_ready", 64'(req_ready_o), 64'b001);
        tick();
        req_valid_i = 3'b000;
        chk("raw_wr_en_T1", 64'(wr_en_o), 64'd1);
        chk("raw_wr_addr_T1", 64'(wr_addr_o), 64'd8);
        chk("raw_stall_T1", 64'(stall_o), 64'd1);
        tick();
        chk("raw_stall_T2", 64'(stall_o), 64'd0);

        // set/clear collision on x9 (pointer now 1)
        issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        req_valid_i = 3'b100;
        req_addr_i  = {5'd9, 5'd0, 5'd8};
        #1;
        chk("col_ready", 64'(req_ready_o), 64'b100);
        tick();
        req_valid_i = 3'b000;
        issue(1'b1, 5'd9, 1'b1, 5'd0, 5'd0);
        #1;
        chk("col_wr_en", 64'(wr_en_o), 64'd1);
        chk("col_wr_addr", 64'(wr_addr_o), 64'd9);
        chk("col_issue_accept", 64'(stall_o), 64'd0);
        tick();
        issue(1'b1, 5'd0, 1'b0, 5'd0, 5'd9);
        #1;
        chk("col_rs2_stall", 64'(stall_o), 64'd1);
        tick();
        chk("col_rs2_stall_hold", 64'(stall_o), 64'd1);

        // WAW vs. no destination write
        issue(1'b1, 5'd9, 1'b1, 5'd0, 5'd0);
        #1;
        chk("waw_stall", 64'(stall_o), 64'd1);
        issue(1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
        #1;
        chk("rd_no_we_stall", 64'(stall_o), 64'd0);
        issue(1'b0, 5'd9, 1'b1, 5'd9, 5'd9);
        #1;
        chk("no_issue_stall", 64'(stall_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port among NREQ write-back sources (ALU, LSU, CSR/MDU) using round-robin arbitration.
- Registers the winning write onto the register file write interface: write address, write data and write enable.
- Holds a per-register busy scoreboard and raises an issue stall on RAW/WAW hazards against writes not yet committed.
- Sits between the execute/memory write-back sources and the register file, beside the decode/issue stage.

Parameters:
- XLEN, 64, data width; matches register file word width.
- NREQ, 3, number of write-back requesters (2..8).
- AW, 5, register address width (32 architectural registers).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid_i  input  NREQ  per-source write request valid.
- req_ready_o  output  NREQ  per-source grant; handshake = valid & ready; combinational.
- req_addr_i  input  NREQ*AW  packed destination addresses; source k at [k*AW +: AW].
- req_data_i  input  NREQ*XLEN  packed write data; source k at [k*XLEN +: XLEN].
- wr_en_o  output  1  register file write enable (registered).
- wr_addr_o  output  AW  register file write address (registered).
- wr_data_o  output  XLEN  register file write data (registered).
- issue_valid_i  input  1  decode stage presenting an instruction.
- issue_rd_i  input  AW  destination of the presented instruction.
- issue_rd_we_i  input  1  presented instruction writes rd.
- issue_rs1_i  input  AW  source 1 address.
- issue_rs2_i  input  AW  source 2 address.
- stall_o  output  1  hazard; instruction must be held; combinational.

Behaviour:
- Reset (async, rst=1):
  - wr_en_o=0, wr_addr_o=0, wr_data_o=0.
  - Round-robin pointer = 0.
  - All busy bits = 0.
  - Combinational outputs then follow from inputs; req_ready_o is all-zero when no valid.
  - Reset mid-write discards any pending grant.
- Arbitration:
  - At most one grant per cycle, one-hot or zero.
  - Search starts at pointer index and wraps modulo NREQ; the first source with valid=1 wins.
  - The pointer updates to (winner+1) mod NREQ only on a handshake; otherwise it holds.
  - Source k with no valid receives no ready.
  - Sources must hold valid, addr and data stable until the handshake.
- Write stage (1-cycle latency):
  - Handshake at edge T loads wr_addr_o and wr_data_o; wr_en_o=1 during cycle T+1; the register file commits at the end of T+1.
  - If no handshake, wr_en_o=0 next cycle; addr/data hold their previous values.
  - A request to x0 (addr=0) is still granted and consumed, but wr_en_o stays 0 for it.
- Scoreboard, busy[31:1]; busy[0] is hardwired 0:
  - Set: on an edge with issue_valid_i=1, stall_o=0, issue_rd_we_i=1 and issue_rd_i!=0, busy[issue_rd_i] is set.
  - Clear: on an edge with wr_en_o=1, busy[wr_addr_o] is cleared.
  - Same index set and cleared on the same edge: set wins (the new producer owns the register).
- Stall:
  - stall_o = issue_valid_i & (busy[rs1] | busy[rs2] | (issue_rd_we_i & busy[rd])).
  - Index 0 is never busy.
  - A register cleared at the end of T+1 is readable and non-stalling from T+2.
  - No bypass from wr_data_o.
- Arithmetic: pointer width is ceil(log2 NREQ); wraps at NREQ, not at a power of two.

Test Plan:
- Reset: assert rst mid-cycle with req_valid_i=3'b111 -> wr_en_o=0 immediately; after release, first grant goes to source 0 (req_ready_o=3'b001).
- Round robin: all three valid continuously with addrs 5/6/7 and data A/B/C -> grants in order 0,1,2,0; wr_addr_o sequence 5,6,7,5 one cycle after each grant; wr_en_o=1 each cycle.
- Fairness/wrap: only sources 2 and 0 valid, pointer=1 -> grant 2, then 0, then 2; source 1 is never granted.
- x0 drop: source 1 writes addr 0, data 0xDEAD -> req_ready_o[1]=1, next cycle wr_en_o=0; busy bits unchanged.
- RAW hazard: issue rd=8 (accepted), then issue rs1=8 -> stall_o=1; ALU writes addr 8 (handshake at T) -> stall_o=1 through T+1, 0 at T+2.
- Set/clear collision: wr_en_o=1 to addr 9 on the same edge as an accepted issue with rd=9 -> busy[9]=1 afterwards; a following issue with rs2=9 stalls.
